// File: rtl/hicore_wb_arbiter_if.sv
// Execution-unit to ROB write-back bundle. Optional HICORE_WB_ARB_PERF_EN adds wb_conflict_cnt.
// slave = arbiter side, master = execution units / write-back consumer side.
interface hicore_wb_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int PTR_W  = 5,
    parameter int DATA_W = 32,
    parameter int INFO_W = 8
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*PTR_W-1:0]  req_ptr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ*INFO_W-1:0] req_info;
    logic                    flush;
    logic                    wb_wen;
    logic [PTR_W-1:0]        wb_ptr;
    logic [DATA_W-1:0]       wb_rd_data;
    logic [INFO_W-1:0]       wb_info;
    logic [N_REQ-1:0]        wb_src;
`ifdef HICORE_WB_ARB_PERF_EN
    logic [31:0]             wb_conflict_cnt;
`endif

    modport slave (
        input  req_valid, req_ptr, req_data, req_info, flush,
        output req_ready, wb_wen, wb_ptr, wb_rd_data, wb_info, wb_src
`ifdef HICORE_WB_ARB_PERF_EN
        , output wb_conflict_cnt
`endif
    );

    modport master (
        output req_valid, req_ptr, req_data, req_info, flush,
        input  req_ready, wb_wen, wb_ptr, wb_rd_data, wb_info, wb_src
`ifdef HICORE_WB_ARB_PERF_EN
        , input wb_conflict_cnt
`endif
    );
endinterface

// File: rtl/hicore_wb_arbiter.sv
// Round-robin merge of N_REQ 2-entry write-back FIFOs into one registered ROB port; latency 2 edges, no bypass.
// Backpressure: req_ready[i] drops while FIFO i holds 2 entries; HICORE_WB_ARB_PERF_EN adds a conflict counter.
module hicore_wb_arbiter #(
    parameter int N_REQ  = 4,
    parameter int PTR_W  = 5,
    parameter int DATA_W = 32,
    parameter int INFO_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    hicore_wb_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(N_REQ);

    typedef struct packed {
        logic [PTR_W-1:0]  ptr;
        logic [DATA_W-1:0] data;
        logic [INFO_W-1:0] info;
    } ent_t;

    ent_t             r_mem [N_REQ][2];
    logic [1:0]       r_count [N_REQ];
    logic [N_REQ-1:0] r_wr_ptr;
    logic [N_REQ-1:0] r_rd_ptr;
    logic [IDX_W-1:0] r_rr_ptr;

    logic             r_wb_wen;
    logic [PTR_W-1:0] r_wb_ptr;
    logic [DATA_W-1:0] r_wb_data;
    logic [INFO_W-1:0] r_wb_info;
    logic [N_REQ-1:0] r_wb_src;

    ent_t             w_in [N_REQ];
    ent_t             w_head;
    logic [N_REQ-1:0] w_nonempty;
    logic [N_REQ-1:0] w_ready;
    logic [N_REQ-1:0] w_push;
    logic [N_REQ-1:0] w_pop;
    logic [N_REQ-1:0] w_win_oh;
    logic             w_found;
    logic [IDX_W-1:0] w_win;
    logic [IDX_W:0]   w_scan;
    logic [IDX_W-1:0] w_rr_nxt;

    always_comb begin
        w_nonempty = '0;
        w_ready    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_nonempty[i] = (r_count[i] != 2'd0);
            w_ready[i]    = (r_count[i] < 2'd2);
            w_in[i].ptr   = bus.req_ptr[i*PTR_W +: PTR_W];
            w_in[i].data  = bus.req_data[i*DATA_W +: DATA_W];
            w_in[i].info  = bus.req_info[i*INFO_W +: INFO_W];
        end
    end

    assign bus.req_ready = w_ready;
    assign w_push        = bus.req_valid & w_ready & {N_REQ{~bus.flush}};

    // Scan upward from rr_ptr with wrap; only entries already resident can win.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_scan  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_scan >= (IDX_W+1)'(N_REQ)) begin
                w_scan = w_scan - (IDX_W+1)'(N_REQ);
            end
            if (!w_found && w_nonempty[w_scan[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_scan[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_win_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_win_oh[i] = (w_win == IDX_W'(i));
        end
    end

    assign w_pop    = (w_found && !bus.flush) ? w_win_oh : '0;
    assign w_head   = r_mem[w_win][r_rd_ptr[w_win]];
    assign w_rr_nxt = (w_win == IDX_W'(N_REQ-1)) ? '0 : w_win + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_count[i] <= 2'd0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_count[i] <= 2'd0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_push[i]) begin
                    r_wr_ptr[i] <= ~r_wr_ptr[i];
                end
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= ~r_rd_ptr[i];
                end
                r_count[i] <= r_count[i] + {1'b0, w_push[i]} - {1'b0, w_pop[i]};
            end
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wr_ptr[i]] <= w_in[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_wen  <= 1'b0;
            r_wb_ptr  <= '0;
            r_wb_data <= '0;
            r_wb_info <= '0;
            r_wb_src  <= '0;
            r_rr_ptr  <= '0;
        end else if (w_found && !bus.flush) begin
            r_wb_wen  <= 1'b1;
            r_wb_ptr  <= w_head.ptr;
            r_wb_data <= w_head.data;
            r_wb_info <= w_head.info;
            r_wb_src  <= w_win_oh;
            r_rr_ptr  <= w_rr_nxt;
        end else begin
            r_wb_wen  <= 1'b0;
        end
    end

    assign bus.wb_wen     = r_wb_wen;
    assign bus.wb_ptr     = r_wb_ptr;
    assign bus.wb_rd_data = r_wb_data;
    assign bus.wb_info    = r_wb_info;
    assign bus.wb_src     = r_wb_src;

`ifdef HICORE_WB_ARB_PERF_EN
    logic [31:0] r_conflict_cnt;
    logic        w_multi;

    // More than one bit set means at least two requesters competed this cycle.
    assign w_multi = |(w_nonempty & (w_nonempty - 1'b1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict_cnt <= '0;
        end else if (w_multi && !bus.flush && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end
    end

    assign bus.wb_conflict_cnt = r_conflict_cnt;
`endif
endmodule
